// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the pipeline stage register: occupancy state
// encoding and the NOP payload fields that make up an inter-stage bubble.
// Imported by pipe_stage; no logic of its own.
package pipe_stage_pkg;

   // Occupancy of the stage: nothing held, main register only, main plus skid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   // Field values that together form a decode-level no-op.
   localparam logic [7:0]  SUB_TYPE_NOP  = 8'h00;
   localparam logic [2:0]  TYPE_NOP      = 3'b000;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
   localparam logic        WRITE_DISABLE = 1'b0;

   // ID/EX boundary payload layout; 49 bits, zero-extended into the stage word.
   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [4:0]  wd;
      logic        wreg;
   } id_ex_t;

   localparam id_ex_t ID_EX_NOP = '{
      aluop:  SUB_TYPE_NOP,
      alusel: TYPE_NOP,
      reg1:   ZERO_WORD,
      wd:     NOP_REG_ADDR,
      wreg:   WRITE_DISABLE
   };

endpackage

// File: rtl/pipe_stage.sv
// Purpose : pipeline stage register with valid/ready handshake, one-entry skid
//           buffer, synchronous flush and a saturating stall-cycle counter.
// Latency : 1 cycle in_fire -> out_valid; full throughput while out_ready=1.
// Backpr. : in_ready is a flop; one extra entry is absorbed into the skid
//           register after out_ready falls, then in_ready drops.
// Ports   : clk, rst (sync, active-high), flush; in_valid/in_ready/in_data
//           upstream; out_valid/out_ready/out_data downstream; stall_cnt.
module pipe_stage
   import pipe_stage_pkg::*;
#(
   parameter int                DATA_W    = 64,
   parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   main_q, main_d;
   logic [DATA_W-1:0]   skid_q, skid_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                in_fire, out_fire;

   always_comb begin
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      cnt_d    = cnt_q;
      in_fire  = in_valid & in_ready_q;
      out_fire = out_valid_q & out_ready;

      // Stall counter saturates; flush leaves it alone.
      if (out_valid_q && !out_ready && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);

      unique case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               state_d = ST_ONE;
               main_d  = in_data;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire) begin
               state_d = ST_FULL;
               skid_d  = in_data;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
               main_d  = NOP_VALUE;
            end
         end
         ST_FULL: begin
            // in_ready_q is 0 here, so only the drain side can move.
            if (out_fire) begin
               state_d = ST_ONE;
               main_d  = skid_q;
               skid_d  = NOP_VALUE;
            end
         end
         default: begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
         end
      endcase

      // A same-cycle out_fire has already been sampled downstream; any
      // same-cycle in_fire is swallowed by clearing everything.
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = NOP_VALUE;
         skid_d  = NOP_VALUE;
      end

      // Both handshake outputs are registered from the next state so no
      // combinational path reaches them.
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_q      <= NOP_VALUE;
         skid_q      <= NOP_VALUE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: two instances share stimulus, one with a
// non-zero NOP word and 16-bit counter, one with default NOP and 4-bit counter.
// Expected values come from a queue-based model of the stage.
module tb_pipe_stage;

   localparam logic [63:0] NOP_A = 64'hDEAD_0000_0000_BEEF;
   localparam logic [63:0] NOP_B = 64'h0;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [63:0] in_data;

   logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic [63:0] a_out_data, b_out_data;
   logic [15:0] a_stall_cnt;
   logic [3:0]  b_stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: held entries oldest-first, plus the two stall counts.
   logic [63:0] mq[$];
   int          cnt_a, cnt_b;

   always #5 clk = ~clk;

   pipe_stage #(.DATA_W(64), .NOP_VALUE(NOP_A), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .stall_cnt(a_stall_cnt)
   );

   pipe_stage #(.DATA_W(64), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .stall_cnt(b_stall_cnt)
   );

   // Advance the model by the rules of the stage, then one clock edge; returns
   // 1 ns after the edge so outputs are settled and inputs may be changed.
   task automatic tick();
      bit in_f, out_f;
      in_f  = in_valid && (mq.size() < 2);
      out_f = (mq.size() > 0) && out_ready;
      if (rst) begin
         mq.delete();
         cnt_a = 0;
         cnt_b = 0;
      end else begin
         if (mq.size() > 0 && !out_ready) begin
            if (cnt_a < 65535) cnt_a++;
            if (cnt_b < 15) cnt_b++;
         end
         if (flush) mq.delete();
         else begin
            if (out_f) void'(mq.pop_front());
            if (in_f) mq.push_back(in_data);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1; in_valid = 1'b1; in_data = 64'hAA;
      tick(); tick();
      rst = 1'b0; in_valid = 1'b0;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
      n_cmp++; if (a_out_data !== NOP_A) begin n_err++; $display("FAIL reset_out_data got %h want %h", a_out_data, NOP_A); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
      n_cmp++; if (a_stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt got %0d want 0", a_stall_cnt); end
      n_cmp++; if (b_out_data !== NOP_B) begin n_err++; $display("FAIL reset_out_data_b got %h want %h", b_out_data, NOP_B); end
      tick();
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid got %b want 0", a_out_valid); end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = 64'(i);
         tick();
         n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 64'(i)) begin
            n_err++; $display("FAIL stream_data[%0d] got v=%b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, 64'(i)); end
         n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, a_in_ready); end
      end
      in_valid = 1'b0;
      tick();
      n_cmp++; if (a_out_valid !== 1'b0 || a_out_data !== NOP_A) begin
         n_err++; $display("FAIL stream_drain got v=%b d=%h want v=0 d=%h", a_out_valid, a_out_data, NOP_A); end
   endtask

   task automatic test_backpressure();
      int base;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h10;
      tick();
      base = int'(a_stall_cnt);
      out_ready = 1'b0; in_data = 64'h11;
      tick();
      n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_drop got %b want 0", a_in_ready); end
      in_data = 64'h12;
      for (int k = 0; k < 3; k++) tick();
      n_cmp++; if (a_out_data !== 64'h10 || a_out_valid !== 1'b1) begin
         n_err++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=10", a_out_valid, a_out_data); end
      n_cmp++; if (int'(a_stall_cnt) !== base + 4) begin
         n_err++; $display("FAIL bp_stall_cnt got %0d want %0d", a_stall_cnt, base + 4); end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (a_out_data !== 64'h11 || a_in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_second got d=%h rdy=%b want d=11 rdy=1", a_out_data, a_in_ready); end
      tick();
      n_cmp++; if (a_out_data !== 64'h12 || a_out_valid !== 1'b1) begin
         n_err++; $display("FAIL bp_third got v=%b d=%h want v=1 d=12", a_out_valid, a_out_data); end
      in_valid = 1'b0;
      tick();
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", a_out_valid); end
   endtask

   task automatic test_flush_full();
      int cnt_before;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h30;
      tick();
      in_data = 64'h31;
      tick();
      cnt_before = int'(a_stall_cnt);
      flush = 1'b1; in_data = 64'h20;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++; if (a_out_valid !== 1'b0 || a_out_data !== NOP_A || a_in_ready !== 1'b1) begin
         n_err++; $display("FAIL flush_full got v=%b d=%h rdy=%b want v=0 d=%h rdy=1", a_out_valid, a_out_data, a_in_ready, NOP_A); end
      n_cmp++; if (int'(a_stall_cnt) !== cnt_before + 1) begin
         n_err++; $display("FAIL flush_keeps_cnt got %0d want %0d", a_stall_cnt, cnt_before + 1); end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (a_out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_dropped[%0d] got v=%b d=%h want v=0", k, a_out_valid, a_out_data); end
      end
   endtask

   task automatic test_flush_fire();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h40;
      tick();
      in_data = 64'h41;
      tick();
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 64'h40) begin
         n_err++; $display("FAIL flush_fire_offer got v=%b d=%h want v=1 d=40", a_out_valid, a_out_data); end
      tick();
      flush = 1'b0;
      n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== NOP_A) begin
         n_err++; $display("FAIL flush_fire_empty got v=%b rdy=%b d=%h want v=0 rdy=1 d=%h", a_out_valid, a_in_ready, a_out_data, NOP_A); end
   endtask

   task automatic test_saturation();
      rst = 1'b1; tick(); rst = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h55;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 19; k++) tick();
      n_cmp++; if (b_stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_cnt4 got %0d want 15", b_stall_cnt); end
      n_cmp++; if (a_stall_cnt !== 16'd19) begin n_err++; $display("FAIL sat_cnt16 got %0d want 19", a_stall_cnt); end
      tick();
      n_cmp++; if (b_stall_cnt !== 4'd15 || a_stall_cnt !== 16'd20) begin
         n_err++; $display("FAIL sat_hold got b=%0d a=%0d want b=15 a=20", b_stall_cnt, a_stall_cnt); end
      out_ready = 1'b1; tick();
   endtask

   task automatic test_random();
      logic        ev;
      logic [63:0] ed_a, ed_b;
      for (int c = 0; c < 2000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         flush     = ($urandom_range(0, 39) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = {$urandom(), $urandom()};
         tick();
         ev   = (mq.size() > 0);
         ed_a = ev ? mq[0] : NOP_A;
         ed_b = ev ? mq[0] : NOP_B;
         n_cmp++; if (a_out_valid !== ev || b_out_valid !== ev) begin
            n_err++; $display("FAIL rnd_valid[%0d] got a=%b b=%b want %b", c, a_out_valid, b_out_valid, ev); end
         n_cmp++; if (a_out_data !== ed_a || b_out_data !== ed_b) begin
            n_err++; $display("FAIL rnd_data[%0d] got a=%h b=%h want a=%h b=%h", c, a_out_data, b_out_data, ed_a, ed_b); end
         n_cmp++; if (a_in_ready !== (mq.size() < 2) || b_in_ready !== (mq.size() < 2)) begin
            n_err++; $display("FAIL rnd_in_ready[%0d] got a=%b b=%b want %b", c, a_in_ready, b_in_ready, mq.size() < 2); end
         n_cmp++; if (int'(a_stall_cnt) !== cnt_a || int'(b_stall_cnt) !== cnt_b) begin
            n_err++; $display("FAIL rnd_stall[%0d] got a=%0d b=%0d want a=%0d b=%0d", c, a_stall_cnt, b_stall_cnt, cnt_a, cnt_b); end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush_full();
      test_flush_fire();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
